// File: rtl/capt_sched.sv
// Capture scheduler: queues packet descriptors, launches one write-controller
// transaction at a time, filters bad descriptors and watches for a hung controller.
module capt_sched #(
   parameter int unsigned DEPTH          = 4,
   parameter logic [15:0] MAX_LEN        = 16'd1518,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     desc_valid,
   output logic                     desc_ready,
   input  logic [31:0]              desc_begin,
   input  logic [31:0]              desc_end,
   output logic                     wr_ctrl,
   input  logic                     wr_ctrl_rdy,
   output logic [31:0]              pkt_begin,
   output logic [31:0]              pkt_end,
   output logic                     busy,
   output logic                     irq,
   output logic                     err,
   output logic [31:0]              pkt_count,
   output logic [31:0]              drop_count,
   output logic [$clog2(DEPTH):0]   queue_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES);
   localparam logic [WW-1:0] WD_LIMIT   = WW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [31:0]   q_begin [DEPTH];
   logic [31:0]   q_end   [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [GW-1:0] gap_cnt;
   logic [WW-1:0] wdog;
   logic [WW-1:0] wdog_inc;
   logic [31:0]   desc_len;
   logic          take;
   logic          bad;
   logic          full;
   logic          push;
   logic          drop;
   logic          pop;
   logic          flush;
   logic          wd_hit;
   logic          done;

   assign desc_ready = enable;
   assign take       = desc_valid & enable;
   assign desc_len   = desc_end - desc_begin;
   assign bad        = (desc_end <= desc_begin) || (desc_len > {16'd0, MAX_LEN});
   // Fullness uses the registered level so a same-cycle pop never rescues a push.
   assign full       = (queue_level == FULL_LEVEL);
   assign push       = take & ~bad & ~full;
   assign drop       = take & (bad | full);
   assign pop        = (state == S_IDLE) && enable && (queue_level != '0);
   assign flush      = ~enable && ((state == S_IDLE) || (state == S_ERROR));
   assign done       = (state == S_WAIT) && wr_ctrl_rdy;
   assign wdog_inc   = wdog + WW'(1);
   assign wd_hit     = (wdog_inc == WD_LIMIT);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (pop) next_state = S_LAUNCH;
         S_LAUNCH: next_state = S_WAIT;
         S_WAIT: begin
            if (wr_ctrl_rdy)  next_state = S_GAP;
            else if (wd_hit)  next_state = S_ERROR;
         end
         S_GAP:    if (gap_cnt <= GW'(1)) next_state = S_IDLE;
         S_ERROR:  if (!enable) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_begin[wr_ptr] <= desc_begin;
         q_end[wr_ptr]   <= desc_end;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         wr_ctrl     <= 1'b0;
         busy        <= 1'b0;
         irq         <= 1'b0;
         err         <= 1'b0;
         pkt_begin   <= '0;
         pkt_end     <= '0;
         pkt_count   <= '0;
         drop_count  <= '0;
         queue_level <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         gap_cnt     <= '0;
         wdog        <= '0;
      end else begin
         state   <= next_state;
         wr_ctrl <= (next_state == S_LAUNCH);
         busy    <= (next_state == S_LAUNCH) || (next_state == S_WAIT) ||
                    (next_state == S_GAP);
         irq     <= done;
         err     <= (next_state == S_ERROR);

         if (pop) begin
            pkt_begin <= q_begin[rd_ptr];
            pkt_end   <= q_end[rd_ptr];
         end

         if (state == S_LAUNCH)
            wdog <= '0;
         else if ((state == S_WAIT) && !wr_ctrl_rdy)
            wdog <= wdog_inc;

         if (done)
            gap_cnt <= GAP_LOAD;
         else if ((state == S_GAP) && (gap_cnt != '0))
            gap_cnt <= gap_cnt - GW'(1);

         if (done && (pkt_count != '1))
            pkt_count <= pkt_count + 32'd1;
         if (drop && (drop_count != '1))
            drop_count <= drop_count + 32'd1;

         // Flush and push are exclusive: both depend on enable with opposite sense.
         if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_level <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
               queue_level <= queue_level + LW'(1);
            else if (pop && !push)
               queue_level <= queue_level - LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_capt_sched.sv
// Self-checking bench for capt_sched: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_capt_sched;

   localparam int DEPTH = 4;
   localparam int GAP   = 2;
   localparam int TMO   = 100;
   localparam int MAXL  = 1518;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        desc_valid = 1'b0;
   logic [31:0] desc_begin = '0;
   logic [31:0] desc_end = '0;
   logic        wr_ctrl_rdy = 1'b0;
   logic        desc_ready;
   logic        wr_ctrl;
   logic [31:0] pkt_begin;
   logic [31:0] pkt_end;
   logic        busy;
   logic        irq;
   logic        err;
   logic [31:0] pkt_count;
   logic [31:0] drop_count;
   logic [2:0]  queue_level;

   int compared = 0;
   int mismatched = 0;
   int wr_pulses = 0;
   int irq_pulses = 0;

   always #5 clk = ~clk;

   capt_sched #(
      .DEPTH(DEPTH),
      .MAX_LEN(16'd1518),
      .GAP_CYCLES(GAP),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .desc_valid(desc_valid),
      .desc_ready(desc_ready),
      .desc_begin(desc_begin),
      .desc_end(desc_end),
      .wr_ctrl(wr_ctrl),
      .wr_ctrl_rdy(wr_ctrl_rdy),
      .pkt_begin(pkt_begin),
      .pkt_end(pkt_end),
      .busy(busy),
      .irq(irq),
      .err(err),
      .pkt_count(pkt_count),
      .drop_count(drop_count),
      .queue_level(queue_level)
   );

   task automatic check_value(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: descriptors in an SV queue, phases named after the behaviour.
   typedef struct packed {
      logic [31:0] b;
      logic [31:0] e;
   } desc_t;
   typedef enum {M_IDLE, M_LAUNCH, M_WAIT, M_GAP, M_ERR} mphase_t;

   desc_t       mq[$];
   mphase_t     ph = M_IDLE;
   int          waited = 0;
   int          gap_left = 0;
   logic [31:0] m_pb = '0, m_pe = '0, m_pc = '0, m_dc = '0;
   logic        m_wr = 1'b0, m_irq = 1'b0, m_err = 1'b0, m_busy = 1'b0;
   logic        do_push;
   desc_t       nd, hd;
   logic [31:0] nlen;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         ph = M_IDLE; waited = 0; gap_left = 0;
         m_pb = '0; m_pe = '0; m_pc = '0; m_dc = '0;
         m_wr = 1'b0; m_irq = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      end else begin
         do_push = 1'b0;
         m_wr = 1'b0;
         m_irq = 1'b0;
         if (desc_valid && enable) begin
            nlen = desc_end - desc_begin;
            if (desc_end <= desc_begin || nlen > 32'(MAXL) || mq.size() >= DEPTH) begin
               if (m_dc != 32'hFFFF_FFFF) m_dc = m_dc + 1;
            end else begin
               do_push = 1'b1;
               nd.b = desc_begin;
               nd.e = desc_end;
            end
         end
         case (ph)
            M_IDLE: begin
               if (!enable) mq.delete();
               else if (mq.size() > 0) begin
                  hd = mq.pop_front();
                  m_pb = hd.b; m_pe = hd.e;
                  m_wr = 1'b1;
                  ph = M_LAUNCH;
               end
            end
            M_LAUNCH: begin
               ph = M_WAIT;
               waited = 0;
            end
            M_WAIT: begin
               if (wr_ctrl_rdy) begin
                  m_irq = 1'b1;
                  if (m_pc != 32'hFFFF_FFFF) m_pc = m_pc + 1;
                  gap_left = GAP;
                  ph = M_GAP;
               end else begin
                  waited++;
                  if (waited == TMO - 1) begin
                     m_err = 1'b1;
                     ph = M_ERR;
                  end
               end
            end
            M_GAP: begin
               gap_left--;
               if (gap_left <= 0) ph = M_IDLE;
            end
            M_ERR: begin
               if (!enable) begin
                  m_err = 1'b0;
                  mq.delete();
                  ph = M_IDLE;
               end
            end
            default: ph = M_IDLE;
         endcase
         if (do_push) mq.push_back(nd);
         m_busy = (ph == M_LAUNCH) || (ph == M_WAIT) || (ph == M_GAP);
      end
   end

   always @(negedge clk) begin
      check_value("desc_ready", 32'(desc_ready), 32'(enable));
      check_value("wr_ctrl", 32'(wr_ctrl), 32'(m_wr));
      check_value("pkt_begin", pkt_begin, m_pb);
      check_value("pkt_end", pkt_end, m_pe);
      check_value("busy", 32'(busy), 32'(m_busy));
      check_value("irq", 32'(irq), 32'(m_irq));
      check_value("err", 32'(err), 32'(m_err));
      check_value("pkt_count", pkt_count, m_pc);
      check_value("drop_count", drop_count, m_dc);
      check_value("queue_level", 32'(queue_level), 32'(mq.size()));
   end

   always @(negedge clk) begin
      if (wr_ctrl) wr_pulses++;
      if (irq)     irq_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] b, input logic [31:0] e);
      desc_valid = 1'b1;
      desc_begin = b;
      desc_end   = e;
   endtask

   // Waits for the next launch; valid and rdy are dropped after the first edge.
   task automatic wait_for_wr(output int n);
      n = 0;
      do begin
         tick();
         desc_valid  = 1'b0;
         wr_ctrl_rdy = 1'b0;
         n++;
      end while (!wr_ctrl && n < 300);
      check_value("launch_seen", 32'(wr_ctrl), 32'd1);
   endtask

   task automatic complete_packet();
      repeat (3) tick();
      wr_ctrl_rdy = 1'b1;
      tick();
      wr_ctrl_rdy = 1'b0;
      repeat (6) tick();
   endtask

   initial begin
      int n;
      repeat (3) tick();
      check_value("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
      check_value("rst_busy", 32'(busy), 32'd0);
      check_value("rst_pkt_count", pkt_count, 32'd0);
      check_value("rst_drop_count", drop_count, 32'd0);
      check_value("rst_queue_level", 32'(queue_level), 32'd0);
      check_value("rst_pkt_begin", pkt_begin, 32'd0);
      reset  = 1'b1;
      enable = 1'b1;
      tick();

      // Single packet with latency pins
      offer(32'h100, 32'h140);
      tick();
      desc_valid = 1'b0;
      check_value("lat_wr_e0", 32'(wr_ctrl), 32'd0);
      check_value("lat_level_e0", 32'(queue_level), 32'd1);
      tick();
      check_value("lat_wr_e1", 32'(wr_ctrl), 32'd1);
      check_value("single_begin", pkt_begin, 32'h100);
      check_value("single_end", pkt_end, 32'h140);
      check_value("single_busy", 32'(busy), 32'd1);
      repeat (19) tick();
      wr_ctrl_rdy = 1'b1;
      tick();
      wr_ctrl_rdy = 1'b0;
      check_value("single_irq", 32'(irq), 32'd1);
      check_value("single_pkt_count", pkt_count, 32'd1);
      repeat (6) tick();
      check_value("single_wr_pulses", 32'(wr_pulses), 32'd1);
      check_value("single_irq_pulses", 32'(irq_pulses), 32'd1);
      check_value("single_drop", drop_count, 32'd0);

      // Overflow and FIFO order with back-to-back spacing
      for (int i = 0; i < 6; i++) begin
         offer(32'h1000 * (i + 1), 32'h1000 * (i + 1) + 32'h40);
         tick();
      end
      desc_valid = 1'b0;
      check_value("ovf_level", 32'(queue_level), 32'd4);
      check_value("ovf_drop", drop_count, 32'd1);
      for (int k = 0; k < 5; k++) begin
         check_value("fifo_begin", pkt_begin, 32'h1000 * (k + 1));
         repeat (3) tick();
         wr_ctrl_rdy = 1'b1;
         if (k < 4) begin
            wait_for_wr(n);
            check_value("b2b_spacing", 32'(n), 32'd4);
         end else begin
            tick();
            wr_ctrl_rdy = 1'b0;
         end
      end
      repeat (6) tick();
      check_value("ovf_pkt_count", pkt_count, 32'd6);
      check_value("ovf_wr_pulses", 32'(wr_pulses), 32'd6);

      // Filtering
      offer(32'h200, 32'h200); tick();
      offer(32'h300, 32'h2FF); tick();
      offer(32'h400, 32'h400 + 32'd1519); tick();
      desc_valid = 1'b0;
      repeat (4) tick();
      check_value("filt_drop", drop_count, 32'd4);
      check_value("filt_no_launch", 32'(wr_pulses), 32'd6);
      offer(32'h500, 32'h500 + 32'd1518);
      wait_for_wr(n);
      check_value("filt_latency", 32'(n), 32'd2);
      check_value("filt_max_end", pkt_end, 32'h500 + 32'd1518);
      complete_packet();
      check_value("filt_pkt_count", pkt_count, 32'd7);

      // Watchdog
      offer(32'h600, 32'h640);
      wait_for_wr(n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!err && n < 200);
      check_value("wd_cycles", 32'(n), 32'd100);
      check_value("wd_err", 32'(err), 32'd1);
      offer(32'h610, 32'h650); tick();
      offer(32'h620, 32'h660); tick();
      desc_valid = 1'b0;
      repeat (10) tick();
      check_value("wd_err_level", 32'(queue_level), 32'd2);
      check_value("wd_no_launch", 32'(wr_pulses), 32'd8);
      check_value("wd_err_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      tick();
      check_value("wd_err_clear", 32'(err), 32'd0);
      check_value("wd_flush", 32'(queue_level), 32'd0);
      enable = 1'b1;
      offer(32'h700, 32'h740);
      wait_for_wr(n);
      check_value("wd_relaunch", pkt_begin, 32'h700);
      complete_packet();
      check_value("wd_pkt_count", pkt_count, 32'd8);

      // Disable during an in-flight packet
      for (int i = 0; i < 4; i++) begin
         offer(32'h800 + 32'h100 * i, 32'h820 + 32'h100 * i);
         tick();
      end
      desc_valid = 1'b0;
      check_value("dis_level", 32'(queue_level), 32'd3);
      repeat (3) tick();
      enable = 1'b0;
      repeat (3) tick();
      wr_ctrl_rdy = 1'b1;
      tick();
      wr_ctrl_rdy = 1'b0;
      check_value("dis_irq", 32'(irq), 32'd1);
      check_value("dis_pkt_count", pkt_count, 32'd9);
      repeat (8) tick();
      check_value("dis_flush", 32'(queue_level), 32'd0);
      check_value("dis_drop", drop_count, 32'd4);
      check_value("dis_wr_pulses", 32'(wr_pulses), 32'd10);

      // Asynchronous reset during WAIT
      enable = 1'b1;
      offer(32'hB00, 32'hB40);
      wait_for_wr(n);
      repeat (3) tick();
      #2 reset = 1'b0;
      #1;
      check_value("arst_busy", 32'(busy), 32'd0);
      check_value("arst_pkt_count", pkt_count, 32'd0);
      check_value("arst_drop", drop_count, 32'd0);
      check_value("arst_pkt_begin", pkt_begin, 32'd0);
      check_value("arst_pkt_end", pkt_end, 32'd0);
      tick();
      reset = 1'b1;
      wr_ctrl_rdy = 1'b1;
      tick();
      wr_ctrl_rdy = 1'b0;
      repeat (4) tick();
      check_value("arst_stray_rdy", pkt_count, 32'd0);
      check_value("arst_irq_pulses", 32'(irq_pulses), 32'd9);
      check_value("arst_wr_pulses", 32'(wr_pulses), 32'd11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/capt_sched.md
Name: capt_sched

Overview:
- Capture scheduler placed in front of the capture write controller.
- Accepts packet descriptors (begin/end byte addresses in the packet staging area) from the packet-detect logic and queues them.
- Launches one write-controller transaction per packet and waits for its completion before launching the next.
- Filters malformed descriptors, counts captured and dropped packets, raises a per-packet completion interrupt, and traps a hung write controller with a watchdog.

Parameters:
DEPTH, 4, descriptor queue entries; power of two, at least 2
MAX_LEN, 16'd1518, largest accepted packet length in bytes
GAP_CYCLES, 2, idle cycles after wr_ctrl_rdy before the next launch; covers the controller's DONE->IDLE return
TIMEOUT_CYCLES, 65535, cycles in WAIT without wr_ctrl_rdy before an error is declared

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  capture enable from the control register
desc_valid  in  1  descriptor offered this cycle
desc_ready  out  1  descriptor consumed this cycle (queued or dropped); equals enable
desc_begin  in  32  packet start address
desc_end  in  32  packet end address (exclusive)
wr_ctrl  out  1  one-cycle start pulse to the write controller
wr_ctrl_rdy  in  1  one-cycle completion pulse from the write controller
pkt_begin  out  32  begin address of the launched packet; stable from launch until the next launch
pkt_end  out  32  end address of the launched packet; same stability rule as pkt_begin
busy  out  1  high in LAUNCH, WAIT and GAP
irq  out  1  one-cycle pulse per completed packet
err  out  1  sticky watchdog error
pkt_count  out  32  completed packets, saturating
drop_count  out  32  dropped descriptors, saturating
queue_level  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset values: every output is 0, state is IDLE, the queue is empty.
- All outputs are registered except desc_ready, which is driven directly from enable.
- Acceptance: a descriptor is taken when desc_valid and enable are both high.
  - Length is desc_end - desc_begin, computed in 32 bits.
  - Drop with drop_count+1 if desc_end <= desc_begin, length > MAX_LEN, or the queue is full.
  - Full is judged on the registered occupancy, so a push into a full queue is dropped even if a pop happens in the same cycle.
  - Otherwise the descriptor is pushed.
- State IDLE:
  - If the queue is non-empty and enable is high: pop, load pkt_begin/pkt_end, go to LAUNCH.
  - If enable is low: flush the queue with no count change.
- State LAUNCH: wr_ctrl=1 for exactly this cycle, then go to WAIT with the watchdog cleared.
- State WAIT:
  - On wr_ctrl_rdy: irq=1 next cycle, pkt_count+1, go to GAP with the gap counter loaded to GAP_CYCLES.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 without wr_ctrl_rdy: set err and go to ERROR.
- State GAP: count down; when the count reaches 0, go to IDLE.
- State ERROR:
  - Hold wr_ctrl low, keep accepting and dropping descriptors as normal.
  - When enable goes low: clear err, flush the queue, go to IDLE.
- Latency: a descriptor accepted at edge E0 into an empty queue with the FSM in IDLE is popped at E1. wr_ctrl is high between E1 and E2.
- Back-to-back packets: from the wr_ctrl_rdy cycle to the next wr_ctrl pulse is GAP_CYCLES+2 cycles.
- wr_ctrl_rdy outside WAIT is ignored and not counted.
- enable deasserted in LAUNCH, WAIT or GAP: the in-flight packet completes and is counted. The queue is flushed on return to IDLE.
- Counters saturate at 32'hFFFFFFFF and are cleared only by reset.
- Asserting reset in any state immediately returns everything to reset values. No wr_ctrl pulse is produced while reset is low.

Test Plan:
- Single packet: begin=0x100, end=0x140, wr_ctrl_rdy 20 cycles after launch -> one wr_ctrl pulse; pkt_begin=0x100, pkt_end=0x140; irq once; pkt_count=1; drop_count=0.
- Queue overflow: DEPTH=4, 6 valid descriptors on consecutive cycles, wr_ctrl_rdy held off -> queue_level reaches 4 and drop_count=1 (one pop frees a slot). Then 5 launches in FIFO order, each spaced ≥ GAP_CYCLES+2 cycles after the previous wr_ctrl_rdy.
- Filtering: end==begin, end<begin, and length=1519 -> drop_count=3, no wr_ctrl; length=1518 -> launched.
- Watchdog: TIMEOUT_CYCLES=100, no wr_ctrl_rdy -> err=1 on cycle 100 of WAIT, then no further wr_ctrl. Drop enable -> err=0, queue_level=0; re-enable plus a new descriptor -> normal launch.
- Disable mid-packet: 3 queued, enable low during WAIT -> the current packet completes (pkt_count+1, irq); queue_level goes to 0 in IDLE; drop_count is unchanged.
- Async reset asserted during WAIT -> all outputs are 0 immediately. A stray wr_ctrl_rdy after release is ignored (pkt_count stays 0).
